// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
// Statistics counters are built only when PIPE_STAGE_STATS_EN is defined.
package pipe_pkg;

    localparam int unsigned PIPE_CTRL_W = 14;
    localparam int unsigned PIPE_DATA_W = 175;
    localparam int unsigned PIPE_CNT_W  = 16;

    // Occupancy of the stage: nothing, main entry only, main plus skid entry
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // Bit offsets of the decode->execute control bundle
    localparam int unsigned IDEX_REGWRITE      = 13;
    localparam int unsigned IDEX_ALUSRC        = 12;
    localparam int unsigned IDEX_RESULTSRC_LSB = 10;
    localparam int unsigned IDEX_MEMWRITE      = 9;
    localparam int unsigned IDEX_JUMP          = 8;
    localparam int unsigned IDEX_BRANCH        = 7;
    localparam int unsigned IDEX_ALUCTRL_LSB   = 3;
    localparam int unsigned IDEX_JALSRC        = 2;
    localparam int unsigned IDEX_USRC          = 1;
    localparam int unsigned IDEX_UOCTRL        = 0;

    // Decode->execute control bundle, MSB first matching the offsets above
    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [3:0] alu_ctrl;
        logic       jal_src;
        logic       u_src;
        logic       uo_ctrl;
    } idex_ctrl_t;

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating stall/bubble/flush cycle counters for one pipeline stage.
// Instantiated by pipe_stage_reg only when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_stats
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = PIPE_CNT_W
)(
    input  logic             CLK,
    input  logic             CLR,
    input  logic             stall_i,
    input  logic             bubble_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [CNT_W-1:0] stall_q,  stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [CNT_W-1:0] flush_q,  flush_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Next counter values: increment on condition, stick at all-ones
    always_comb begin
        stall_d  = sat_inc(stall_q,  stall_i);
        bubble_d = sat_inc(bubble_q, bubble_i);
        flush_d  = sat_inc(flush_q,  flush_i);
    end

    // Counter registers, cleared only by CLR
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end

    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;
    assign flush_cnt_o  = flush_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake, 2-entry skid buffer,
// synchronous flush, registered in_ready. Control bundle reads zero when empty.
// Optional statistics counters enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = PIPE_CTRL_W,
`ifdef PIPE_STAGE_STATS_EN
    parameter int unsigned CNT_W  = PIPE_CNT_W,
`endif
    parameter int unsigned DATA_W = PIPE_DATA_W
)(
    input  logic              CLK,
    input  logic              CLR,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_STATS_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic [DATA_W-1:0] out_data
);

    pipe_state_e       state_q,     state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q,  in_ready_d;
    logic              accept_c;
    logic              consume_c;

    // Next-state and entry movement; ctrl is zeroed whenever a slot becomes empty
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        accept_c    = in_valid & in_ready_q;
        consume_c   = out_valid_q & out_ready;

        if (flush_i) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_FULL: begin
                    if (accept_c && consume_c) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept_c) begin
                        state_d     = ST_SKID;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (consume_c) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                ST_SKID: begin
                    if (consume_c) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_SKID);
    end

    // State, payload and handshake registers
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

`ifdef PIPE_STAGE_STATS_EN
    pipe_stage_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .CLK          (CLK),
        .CLR          (CLR),
        .stall_i      (out_valid_q & ~out_ready),
        .bubble_i     (~out_valid_q),
        .flush_i      (flush_i),
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt),
        .flush_cnt_o  (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the driver pushes accepted entries into a
// queue (a 2-deep FIFO model), the monitor pops on consumption and checks outputs.
// Define PIPE_STAGE_STATS_EN to build and check the counters (CNT_W = 4).
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned CW = PIPE_CTRL_W;
    localparam int unsigned DW = PIPE_DATA_W;
`ifdef PIPE_STAGE_STATS_EN
    localparam int unsigned NW = 4;
`endif

    logic          CLK = 1'b0;
    logic          CLR;
    logic          flush_i;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [NW-1:0] stall_cnt, bubble_cnt, flush_cnt;
    logic [NW-1:0] e_stall, e_bubble, e_flush;
`endif

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] last_data;
    logic          p_valid, p_ordy, p_flush, p_consume;
    int            checks   = 0;
    int            failures = 0;

    pipe_stage_reg #(
        .CTRL_W (CW),
`ifdef PIPE_STAGE_STATS_EN
        .CNT_W  (NW),
`endif
        .DATA_W (DW)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .flush_i    (flush_i),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
`ifdef PIPE_STAGE_STATS_EN
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt),
`endif
        .out_data   (out_data)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] small_data(input int v);
        return DW'(v);
    endfunction

    task automatic model_reset();
        q.delete();
        last_data = '0;
        p_valid   = 1'b0;
        p_ordy    = 1'b0;
        p_flush   = 1'b0;
        p_consume = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
        e_stall  = '0;
        e_bubble = '0;
        e_flush  = '0;
`endif
    endtask

    // One clock of stimulus, driven on the falling edge; acc reports whether the entry is taken
    task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic fl, output logic acc);
        ent_t e;
        @(negedge CLK);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush_i   = fl;
        p_valid   = (q.size() > 0);
        p_ordy    = ordy;
        p_flush   = fl;
        p_consume = p_valid && ordy;
        acc       = v && !fl && (q.size() < 2);
        if (acc) begin
            e.c = c;
            e.d = d;
            q.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy, input logic fl);
        logic a;
        cycle(1'b0, CW'(0), rnd_data(), ordy, fl, a);
    endtask

    // Monitor: apply the edge's consume/flush to the model, then compare outputs
    initial begin
        model_reset();
        forever begin
            @(posedge CLK);
            #1;
            if (CLR) begin
                model_reset();
                continue;
            end
`ifdef PIPE_STAGE_STATS_EN
            if (p_valid && !p_ordy && e_stall != '1) e_stall++;
            if (!p_valid && e_bubble != '1) e_bubble++;
            if (p_flush && e_flush != '1) e_flush++;
`endif
            if (p_flush) q.delete();
            else if (p_consume) void'(q.pop_front());
            chk("out_valid", 192'(out_valid), 192'(q.size() > 0));
            chk("in_ready", 192'(in_ready), 192'(q.size() < 2));
            if (q.size() > 0) begin
                chk("out_ctrl", 192'(out_ctrl), 192'(q[0].c));
                chk("out_data", 192'(out_data), 192'(q[0].d));
                last_data = q[0].d;
            end else begin
                chk("out_ctrl_gated", 192'(out_ctrl), 192'(0));
                chk("out_data_held", 192'(out_data), 192'(last_data));
            end
`ifdef PIPE_STAGE_STATS_EN
            chk("stall_cnt", 192'(stall_cnt), 192'(e_stall));
            chk("bubble_cnt", 192'(bubble_cnt), 192'(e_bubble));
            chk("flush_cnt", 192'(flush_cnt), 192'(e_flush));
`endif
        end
    end

    // Asynchronous CLR pulse in the middle of a cycle, checked immediately
    task automatic do_reset();
        @(posedge CLK);
        #3;
        CLR       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush_i   = 1'b0;
        #1;
        chk("rst_out_valid", 192'(out_valid), 192'(0));
        chk("rst_in_ready", 192'(in_ready), 192'(1));
        chk("rst_out_ctrl", 192'(out_ctrl), 192'(0));
        chk("rst_out_data", 192'(out_data), 192'(0));
`ifdef PIPE_STAGE_STATS_EN
        chk("rst_stall_cnt", 192'(stall_cnt), 192'(0));
`endif
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    initial begin
        logic a;
        bit   got;
        CLR       = 1'b1;
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        chk("init_out_valid", 192'(out_valid), 192'(0));
        chk("init_in_ready", 192'(in_ready), 192'(1));
        @(negedge CLK);
        CLR = 1'b0;

`ifdef PIPE_STAGE_STATS_EN
        // Stall counter saturates; flush counts without clearing it
        do_reset();
        cycle(1'b1, CW'(5), small_data(77), 1'b0, 1'b0, a);
        repeat (20) idle(1'b0, 1'b0);
        @(posedge CLK);
        #2;
        chk("stats_stall_sat", 192'(stall_cnt), 192'(4'hF));
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        @(posedge CLK);
        #2;
        chk("stats_flush_two", 192'(flush_cnt), 192'(2));
        chk("stats_stall_kept", 192'(stall_cnt), 192'(4'hF));
`endif

        // Streaming 1..8 at full throughput
        for (int i = 1; i <= 8; i++) cycle(1'b1, CW'(i), small_data(i), 1'b1, 1'b0, a);
        repeat (2) idle(1'b1, 1'b0);

        // Backpressure: A, B fill the stage, C waits upstream until space
        cycle(1'b1, CW'(10), small_data(16'hA), 1'b0, 1'b0, a);
        cycle(1'b1, CW'(11), small_data(16'hB), 1'b0, 1'b0, a);
        cycle(1'b1, CW'(12), small_data(16'hC), 1'b0, 1'b0, a);
        got = a;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle(1'b1, CW'(12), small_data(16'hC), 1'b1, 1'b0, a);
            got = a;
        end
        chk("bp_c_accepted", 192'(got), 192'(1));
        repeat (4) idle(1'b1, 1'b0);

        // Flush from SKID with a valid input present
        cycle(1'b1, CW'(14'h3FFF), small_data(16'h111), 1'b0, 1'b0, a);
        cycle(1'b1, CW'(14'h3FFF), small_data(16'h222), 1'b0, 1'b0, a);
        cycle(1'b1, CW'(14'h3FFF), small_data(16'h333), 1'b0, 1'b1, a);
        repeat (3) idle(1'b1, 1'b0);

        // Bubbles after one entry drains: ctrl gated, data held
        cycle(1'b1, CW'(14'h2AAA), small_data(16'h5A5A), 1'b1, 1'b0, a);
        repeat (4) idle(1'b1, 1'b0);

        // Randomised traffic with occasional flushes
        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(0, 9) < 7), CW'($urandom()), rnd_data(),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3), a);
        end

        // CLR in the SKID state, then more traffic
        cycle(1'b1, CW'(1), small_data(1), 1'b0, 1'b0, a);
        cycle(1'b1, CW'(2), small_data(2), 1'b0, 1'b0, a);
        do_reset();
        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 1) == 1), CW'($urandom()), rnd_data(),
                  ($urandom_range(0, 3) != 0), 1'b0, a);
        end

        idle(1'b1, 1'b0);
        @(posedge CLK);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
